vga_box_engine: RTL



---
 rtl/vga_pkg.sv | 32 +++
 rtl/vga_timing.sv | 92 +++++++++
 rtl/vga_box_engine.sv | 135 +++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared timing defaults, coordinate width and helpers for the
// VGA timing generator and box overlay.
//   - *_DEF localparams: standard 640x480 @ 60 Hz timing (25 MHz pixel clock)
//   - total4(): sum of the four segments of a line or a frame
//   - move_req_t: one bit per move direction (pending requests)
package vga_pkg;

    localparam int CW_DEF       = 12;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    function automatic int total4(input int active, input int fp,
                                  input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    typedef struct packed {
        logic left;
        logic right;
        logic up;
        logic down;
    } move_req_t;

endpackage

// File: rtl/vga_timing.sv
// vga_timing: horizontal/vertical counters and registered sync/video outputs.
// Ports:
//   clk, rst_n      pixel clock, async active-low reset
//   h_sync, v_sync  registered syncs (SYNC_POL during the sync interval)
//   video_on        registered active-region flag
//   pix_x, pix_y    registered counter values (also valid in blanking)
//   frame_start     registered pulse, one cycle after the apply point
//   hcnt, vcnt      raw counters for logic aligned with the outputs above
//   active          combinational active-region flag for the raw counters
//   apply           combinational frame-boundary strobe (hcnt==0, vcnt==V_ACTIVE)
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter bit SYNC_POL = 1'b0,
    parameter int CW       = CW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          h_sync,
    output logic          v_sync,
    output logic          video_on,
    output logic [CW-1:0] pix_x,
    output logic [CW-1:0] pix_y,
    output logic          frame_start,
    output logic [CW-1:0] hcnt,
    output logic [CW-1:0] vcnt,
    output logic          active,
    output logic          apply
);

    localparam int H_TOTAL = total4(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = total4(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic hs_c, vs_c;

    always_comb begin
        hs_c   = (hcnt >= HS_BEG && hcnt < HS_END) ? SYNC_POL : ~SYNC_POL;
        vs_c   = (vcnt >= VS_BEG && vcnt < VS_END) ? SYNC_POL : ~SYNC_POL;
        active = (hcnt < H_ACT) && (vcnt < V_ACT);
        apply  = (hcnt == '0) && (vcnt == V_ACT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == H_LAST) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

    // Every output is a register of the current counters, so they all sit
    // exactly one cycle behind hcnt/vcnt and stay mutually aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_sync      <= ~SYNC_POL;
            v_sync      <= ~SYNC_POL;
            video_on    <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            frame_start <= 1'b0;
        end else begin
            h_sync      <= hs_c;
            v_sync      <= vs_c;
            video_on    <= active;
            pix_x       <= hcnt;
            pix_y       <= vcnt;
            frame_start <= apply;
        end
    end

endmodule

// File: rtl/vga_box_engine.sv
// vga_box_engine: VGA timing plus a movable solid box overlay.
// Ports:
//   clk, rst_n            pixel clock, async active-low reset
//   move_left/right/up/down  single-cycle move requests (sticky until the
//                         next frame boundary)
//   h_sync, v_sync, video_on, pix_x, pix_y, frame_start  from vga_timing
//   box_on                registered, aligned with the other outputs
// The box moves only at the frame boundary (start of vertical blanking) so
// a visible frame never shows two box positions.
module vga_box_engine
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter bit SYNC_POL = 1'b0,
    parameter int BOX_W    = 200,
    parameter int BOX_H    = 200,
    parameter int INIT_X   = 220,
    parameter int INIT_Y   = 140,
    parameter int STEP     = 8,
    parameter int CW       = CW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          move_left,
    input  logic          move_right,
    input  logic          move_up,
    input  logic          move_down,
    output logic          h_sync,
    output logic          v_sync,
    output logic          video_on,
    output logic [CW-1:0] pix_x,
    output logic [CW-1:0] pix_y,
    output logic          box_on,
    output logic          frame_start
);

    localparam int H_TOTAL = total4(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = total4(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (BOX_W > H_ACTIVE || BOX_H > V_ACTIVE) begin : g_bad_box
        $error("vga_box_engine: box larger than active area");
    end
    if (INIT_X < 0 || INIT_X > H_ACTIVE - BOX_W ||
        INIT_Y < 0 || INIT_Y > V_ACTIVE - BOX_H) begin : g_bad_init
        $error("vga_box_engine: initial box position out of range");
    end
    if (H_TOTAL >= (1 << CW) || V_TOTAL >= (1 << CW)) begin : g_bad_cw
        $error("vga_box_engine: CW too narrow for line/frame totals");
    end

    // One extra bit of headroom so +STEP cannot overflow before clamping.
    localparam logic [CW:0] X_MAX  = (CW+1)'(H_ACTIVE - BOX_W);
    localparam logic [CW:0] Y_MAX  = (CW+1)'(V_ACTIVE - BOX_H);
    localparam logic [CW:0] STEP_E = (CW+1)'(STEP);
    localparam logic [CW:0] BOXW_E = (CW+1)'(BOX_W);
    localparam logic [CW:0] BOXH_E = (CW+1)'(BOX_H);

    logic [CW-1:0] hcnt, vcnt;
    logic          active, apply;

    vga_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .SYNC_POL(SYNC_POL), .CW(CW)
    ) u_timing (
        .clk        (clk),
        .rst_n      (rst_n),
        .h_sync     (h_sync),
        .v_sync     (v_sync),
        .video_on   (video_on),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .frame_start(frame_start),
        .hcnt       (hcnt),
        .vcnt       (vcnt),
        .active     (active),
        .apply      (apply)
    );

    move_req_t     req, pend, pend_nxt;
    logic [CW-1:0] box_x, box_y, box_x_nxt, box_y_nxt;
    logic [CW:0]   x_e, y_e, x_dec, x_inc, y_dec, y_inc;
    logic          hit;

    assign req = '{left: move_left, right: move_right, up: move_up, down: move_down};

    always_comb begin
        x_e   = {1'b0, box_x};
        y_e   = {1'b0, box_y};
        // Saturate at both ends; compare before subtracting so 0 never wraps.
        x_dec = (x_e < STEP_E) ? '0 : x_e - STEP_E;
        x_inc = (x_e + STEP_E > X_MAX) ? X_MAX : x_e + STEP_E;
        y_dec = (y_e < STEP_E) ? '0 : y_e - STEP_E;
        y_inc = (y_e + STEP_E > Y_MAX) ? Y_MAX : y_e + STEP_E;

        box_x_nxt = box_x;
        box_y_nxt = box_y;
        if (pend.left && !pend.right)  box_x_nxt = x_dec[CW-1:0];
        if (pend.right && !pend.left)  box_x_nxt = x_inc[CW-1:0];
        if (pend.up && !pend.down)     box_y_nxt = y_dec[CW-1:0];
        if (pend.down && !pend.up)     box_y_nxt = y_inc[CW-1:0];

        // A request landing on the apply cycle itself survives into the
        // next frame instead of being swallowed by the clear.
        pend_nxt = apply ? req : (pend | req);

        hit = active &&
              ({1'b0, hcnt} >= x_e) && ({1'b0, hcnt} < x_e + BOXW_E) &&
              ({1'b0, vcnt} >= y_e) && ({1'b0, vcnt} < y_e + BOXH_E);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            box_x  <= CW'(INIT_X);
            box_y  <= CW'(INIT_Y);
            pend   <= '0;
            box_on <= 1'b0;
        end else begin
            pend   <= pend_nxt;
            box_on <= hit;
            if (apply) begin
                box_x <= box_x_nxt;
                box_y <= box_y_nxt;
            end
        end
    end

endmodule
